// File: rtl/pong_game_ctrl.sv
// Match-level sequencer for the pong datapath: game FSM, score counters,
// ball-engine gating, serve direction and winner flag.
module pong_game_ctrl #(
   parameter int WIN_SCORE    = 5,
   parameter int SERVE_FRAMES = 60,
   parameter int POINT_FRAMES = 90
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       btn_start,
   input  logic       miss_left,
   input  logic       miss_right,
   output logic       ball_en,
   output logic       ball_hold,
   output logic       serve_dir,
   output logic [3:0] score_l,
   output logic [3:0] score_r,
   output logic       game_over,
   output logic       winner,
   output logic [2:0] state
);

   localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
   localparam int CW         = $clog2(MAX_FRAMES + 1);

   localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);
   localparam logic [CW-1:0] POINT_LAST = CW'(POINT_FRAMES - 1);
   localparam logic [3:0]    WIN_VAL    = 4'(WIN_SCORE);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      PLAY  = 3'd2,
      POINT = 3'd3,
      OVER  = 3'd4
   } state_t;

   state_t          cur_state, nxt_state;
   logic [CW-1:0]   frame_cnt, nxt_frame_cnt;
   logic [3:0]      nxt_score_l, nxt_score_r;
   logic            nxt_serve_dir, nxt_winner;
   logic [2:0]      btn_sync;
   logic            start_pulse;

   // Two stages resolve metastability; the third is the edge detector's history.
   assign start_pulse = btn_sync[1] & ~btn_sync[2];

   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      nxt_state     = cur_state;
      nxt_frame_cnt = frame_cnt;
      nxt_score_l   = score_l;
      nxt_score_r   = score_r;
      nxt_serve_dir = serve_dir;
      nxt_winner    = winner;
      case (cur_state)
         IDLE: begin
            if (start_pulse) begin
               nxt_state     = SERVE;
               nxt_score_l   = '0;
               nxt_score_r   = '0;
               nxt_serve_dir = 1'b1;
            end
         end
         SERVE: begin
            if (frame_tick) begin
               if (frame_cnt == SERVE_LAST) nxt_state = PLAY;
               else                         nxt_frame_cnt = frame_cnt + 1'b1;
            end
         end
         PLAY: begin
            if (miss_left && miss_right) begin
               nxt_state = POINT;
            end else if (miss_left) begin
               nxt_state     = POINT;
               nxt_serve_dir = 1'b0;
               if (score_r < WIN_VAL) nxt_score_r = score_r + 4'd1;
            end else if (miss_right) begin
               nxt_state     = POINT;
               nxt_serve_dir = 1'b1;
               if (score_l < WIN_VAL) nxt_score_l = score_l + 4'd1;
            end
         end
         POINT: begin
            if (frame_tick) begin
               if (frame_cnt == POINT_LAST) begin
                  if (score_l == WIN_VAL || score_r == WIN_VAL) begin
                     nxt_state  = OVER;
                     nxt_winner = (score_r == WIN_VAL);
                  end else begin
                     nxt_state = SERVE;
                  end
               end else begin
                  nxt_frame_cnt = frame_cnt + 1'b1;
               end
            end
         end
         OVER: begin
            if (start_pulse) begin
               nxt_state     = SERVE;
               nxt_score_l   = '0;
               nxt_score_r   = '0;
               nxt_winner    = 1'b0;
               nxt_serve_dir = 1'b1;
            end
         end
         default: nxt_state = IDLE;
      endcase
      if (nxt_state != cur_state) nxt_frame_cnt = '0;
   end

   // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_state <= IDLE;
         frame_cnt <= '0;
         score_l   <= '0;
         score_r   <= '0;
         serve_dir <= 1'b1;
         winner    <= 1'b0;
         btn_sync  <= '0;
      end else begin
         cur_state <= nxt_state;
         frame_cnt <= nxt_frame_cnt;
         score_l   <= nxt_score_l;
         score_r   <= nxt_score_r;
         serve_dir <= nxt_serve_dir;
         winner    <= nxt_winner;
         btn_sync  <= {btn_sync[1:0], btn_start};
      end
   end

   assign state     = cur_state;
   assign ball_en   = (cur_state == PLAY);
   assign ball_hold = (cur_state == IDLE) || (cur_state == SERVE) || (cur_state == OVER);
   assign game_over = (cur_state == OVER);

endmodule
